// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W       = 28;
    localparam int DEF_DATA_W       = 128;
    localparam int DEF_MAX_D_STREAK = 3;

    localparam logic CLI_I = 1'b0;
    localparam logic CLI_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache: D has priority, but only for a
// bounded streak of grants while I is waiting, so instruction fetch cannot starve.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          r_state;
    logic [STREAK_W-1:0] r_d_streak;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [1:0]          w_req;
    logic                w_grant_d;
    logic                w_grant_i;
    logic [STREAK_W-1:0] w_streak_next;

    // D wins unless I is also waiting and D has already used its full streak.
    always_comb begin
        w_req         = '0;
        w_req[CLI_I]  = i_read | i_write;
        w_req[CLI_D]  = d_read | d_write;
        w_grant_d     = w_req[CLI_D] & (~w_req[CLI_I] | (r_d_streak < STREAK_MAX));
        w_grant_i     = w_req[CLI_I] & ~w_grant_d;
        w_streak_next = '0;
        if (w_grant_d && w_req[CLI_I]) begin
            w_streak_next = (r_d_streak == STREAK_MAX) ? STREAK_MAX : r_d_streak + 1'b1;
        end
    end

    // A simultaneous read+write is issued as the write; the cache retries the read.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state     <= IDLE;
            r_d_streak  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= GRANT_D;
                        r_d_streak  <= w_streak_next;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_write <= d_write;
                        r_mem_read  <= d_read & ~d_write;
                    end else if (w_grant_i) begin
                        r_state     <= GRANT_I;
                        r_d_streak  <= '0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= i_wdata;
                        r_mem_write <= i_write;
                        r_mem_read  <= i_read & ~i_write;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_ready) begin
                        r_state     <= RELEASE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign i_ready = mem_ready & (r_state == GRANT_I);
    assign d_ready = mem_ready & (r_state == GRANT_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
